best_tracker: RTL and testbench
===============================

// Module: best_tracker
// PURPOSE
//  Downstream of the tile: consumes its per-cycle (metric_o, msg_o) stream, discards pipeline-fill garbage,
//  and keeps the highest-metric message seen. Reports each new best to the host via valid/ready, and stops the
//  search once the best metric reaches a host threshold or on host stop.
// PARAMETERS
//  MSG   512*`BLOCKS  message width; matches the tile's msg_o
//  MW    9            metric width; matches the tile's metric_o ($clog2(160+1)+1)
//  LAT   245          cycles from start_i accept until first valid tile output (pipeline fill), >=1
// PORTS
//  clk_i          in   1    clock
//  reset_ni       in   1    reset; synchronous, active-low
//  start_i        in   1    pulse: begin a search (honoured only in IDLE)
//  stop_i         in   1    level/pulse: abort search (honoured in WARM/RUN)
//  thresh_i       in   MW   stop when best metric >= thresh_i; sampled at start_i accept
//  metric_i       in   MW   tile metric_o, cycle-aligned with msg_i
//  msg_i          in   MSG  tile msg_o
//  best_val_o     out  1    report valid
//  best_rdy_i     in   1    host ready; transfer on best_val_o && best_rdy_i
//  best_metric_o  out  MW   reported metric
//  best_msg_o     out  MSG  reported message
//  busy_o         out  1    state != IDLE
//  hit_o          out  1    search ended by threshold (sticky until next start accept)
//  samples_o      out  32   RUN samples examined, saturating at 2^32-1
// BEHAVIOUR
//  Reset (reset_ni==0 at posedge): state=IDLE; best_val_o=0, best_metric_o=0, best_msg_o=0, busy_o=0,
//   hit_o=0, samples_o=0; internal best, have_best, dirty, warm counter, thresh reg cleared. Reset mid-search
//   drops everything including an undelivered report.
//  FSM: IDLE -start_i-> WARM (latch thresh, clear best/have_best/dirty/hit/samples, cnt=LAT-1).
//   WARM: cnt decrements each cycle; at cnt==0 -> RUN next cycle. stop_i -> DRAIN.
//   RUN: each cycle metric_i/msg_i is a valid sample. samples_o+1 (saturate).
//    if !have_best or metric_i > best (unsigned, strict): best<=metric_i, best_msg<=msg_i, have_best<=1, dirty<=1.
//    Ties keep the older message. If the updated (or current) best >= thresh -> hit_o<=1, DRAIN.
//    stop_i -> DRAIN; a sample in the same cycle as stop_i is still evaluated.
//   DRAIN: no samples taken; when dirty==0 and best_val_o==0 -> IDLE.
//  Report path (all non-IDLE states): if !best_val_o && dirty: load best_metric_o/best_msg_o from best,
//   best_val_o<=1, dirty<=0 (one-cycle latency from best update to valid). While best_val_o && !best_rdy_i
//   outputs are frozen; newer bests only set dirty. On transfer, best_val_o<=0; if dirty, reload next cycle
//   (no back-to-back valid; one idle cycle minimum between reports). best_val_o never depends combinationally
//   on best_rdy_i.
//  Update and load in same cycle: load uses the pre-update best; the new best leaves dirty=1.
//  thresh_i==0: first RUN sample hits. Threshold unreachable (>160): runs until stop_i.
//  start_i outside IDLE ignored; start_i and stop_i together in IDLE: start wins, stop ignored.
//  In IDLE, best_val_o stays 0 and outputs hold last reported values.
// TESTING (LAT=4 for all)
//  1 start, thresh=200, metrics 3,7,7,5,9 from RUN cycle 0, rdy=1 -> reports 3,7,9; tie keeps first 7's msg.
//  2 start, first WARM-cycle inputs metric=150 -> ignored; samples_o counts only RUN cycles.
//  3 rdy=0, metrics 10,20,30 -> report 10 held stable; rdy=1 -> 10 then 30 (20 never reported).
//  4 thresh=40, metrics 12,45 -> reports 12,45, hit_o=1, DRAIN->IDLE after last transfer, busy_o=0.
//  5 stop_i in WARM -> IDLE in 2 cycles, no report; stop_i in RUN with metric 60 same cycle -> 60 reported.
//  6 reset_ni=0 mid-RUN with best_val_o=1 -> next cycle all outputs 0, IDLE; new start behaves as test 1.

Source files
------------

// File: rtl/best_if.sv
// Report channel from best_tracker to the host.
// Transfer happens on a clock edge where best_val && best_rdy; best_val never waits on best_rdy.
interface best_if #(
    parameter int MW  = 9,
    parameter int MSG = 512
);
    logic           best_val;
    logic           best_rdy;
    logic [MW-1:0]  best_metric;
    logic [MSG-1:0] best_msg;

    modport master (output best_val, output best_metric, output best_msg, input best_rdy);
    modport slave  (input best_val, input best_metric, input best_msg, output best_rdy);
endinterface

// File: rtl/best_tracker.sv
// Tracks the highest-metric message from the tile stream after pipeline fill and
// reports each new best to the host until threshold, host stop, or reset.
module best_tracker #(
    parameter int MW  = 9,
    parameter int MSG = 512,
    parameter int LAT = 245
) (
    input  logic           clk_i,
    input  logic           reset_ni,
    input  logic           start_i,
    input  logic           stop_i,
    input  logic [MW-1:0]  thresh_i,
    input  logic [MW-1:0]  metric_i,
    input  logic [MSG-1:0] msg_i,
    best_if.master         rpt,
    output logic           busy_o,
    output logic           hit_o,
    output logic [31:0]    samples_o,
    output logic [1:0]     dbg_state_o
);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WARM  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [MW-1:0]  thresh_q, thresh_d;
    logic [MW-1:0]  best_q, best_d;
    logic [MSG-1:0] best_msg_q, best_msg_d;
    logic           have_best_q, have_best_d;
    logic           dirty_q, dirty_d;
    logic           val_q, val_d;
    logic [MW-1:0]  out_metric_q, out_metric_d;
    logic [MSG-1:0] out_msg_q, out_msg_d;
    logic           hit_q, hit_d;
    logic [31:0]    samples_q, samples_d;
    logic           upd;
    logic [MW-1:0]  new_best;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        thresh_d     = thresh_q;
        best_d       = best_q;
        best_msg_d   = best_msg_q;
        have_best_d  = have_best_q;
        dirty_d      = dirty_q;
        val_d        = val_q;
        out_metric_d = out_metric_q;
        out_msg_d    = out_msg_q;
        hit_d        = hit_q;
        samples_d    = samples_q;
        upd          = 1'b0;
        new_best     = best_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_WARM;
                    cnt_d       = CW'(LAT - 1);
                    thresh_d    = thresh_i;
                    best_d      = '0;
                    best_msg_d  = '0;
                    have_best_d = 1'b0;
                    dirty_d     = 1'b0;
                    hit_d       = 1'b0;
                    samples_d   = '0;
                end
            end
            S_WARM: begin
                if (stop_i) begin
                    state_d = S_DRAIN;
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RUN: begin
                if (samples_q != '1) begin
                    samples_d = samples_q + 32'd1;
                end
                // Strict compare: a tie keeps the older message.
                upd      = !have_best_q || (metric_i > best_q);
                new_best = upd ? metric_i : best_q;
                if (new_best >= thresh_q) begin
                    hit_d   = 1'b1;
                    state_d = S_DRAIN;
                end else if (stop_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!dirty_q && !val_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A transfer always leaves one idle cycle before the next load.
        if (state_q != S_IDLE) begin
            if (val_q && rpt.best_rdy) begin
                val_d = 1'b0;
            end else if (!val_q && dirty_q) begin
                out_metric_d = best_q;
                out_msg_d    = best_msg_q;
                val_d        = 1'b1;
                dirty_d      = 1'b0;
            end
        end

        if (upd) begin
            best_d      = metric_i;
            best_msg_d  = msg_i;
            have_best_d = 1'b1;
            dirty_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            thresh_q     <= '0;
            best_q       <= '0;
            best_msg_q   <= '0;
            have_best_q  <= 1'b0;
            dirty_q      <= 1'b0;
            val_q        <= 1'b0;
            out_metric_q <= '0;
            out_msg_q    <= '0;
            hit_q        <= 1'b0;
            samples_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            thresh_q     <= thresh_d;
            best_q       <= best_d;
            best_msg_q   <= best_msg_d;
            have_best_q  <= have_best_d;
            dirty_q      <= dirty_d;
            val_q        <= val_d;
            out_metric_q <= out_metric_d;
            out_msg_q    <= out_msg_d;
            hit_q        <= hit_d;
            samples_q    <= samples_d;
        end
    end

    assign rpt.best_val    = val_q;
    assign rpt.best_metric = out_metric_q;
    assign rpt.best_msg    = out_msg_q;
    assign busy_o          = (state_q != S_IDLE);
    assign hit_o           = hit_q;
    assign samples_o       = samples_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_best_tracker.sv
// Directed bench for best_tracker: expected reports are queued as samples are
// driven and popped by a monitor when the host channel transfers.
module tb_best_tracker;
    localparam int MW  = 9;
    localparam int MSG = 32;
    localparam int LAT = 4;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic           clk = 1'b0;
    logic           reset_ni;
    logic           start_i, stop_i;
    logic [MW-1:0]  thresh_i, metric_i;
    logic [MSG-1:0] msg_i;
    logic           busy_o, hit_o;
    logic [31:0]    samples_o;
    logic [1:0]     dbg_state_o;

    best_if #(.MW(MW), .MSG(MSG)) bif ();

    best_tracker #(.MW(MW), .MSG(MSG), .LAT(LAT)) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .thresh_i    (thresh_i),
        .metric_i    (metric_i),
        .msg_i       (msg_i),
        .rpt         (bif),
        .busy_o      (busy_o),
        .hit_o       (hit_o),
        .samples_o   (samples_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [MW+MSG-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MSG-1:0] mk_msg(input int tn, input int idx);
        return 32'hA500_0000 + MSG'(tn * 256 + idx);
    endfunction

    // Transfer is decided at the next posedge; sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_ni && bif.best_val && bif.best_rdy) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_report observed=%0h expected=none",
                       {bif.best_metric, bif.best_msg});
            end else begin
                check("report", 64'({bif.best_metric, bif.best_msg}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [MW-1:0] t);
        start_i  = 1'b1;
        thresh_i = t;
        step();
        start_i  = 1'b0;
    endtask

    task automatic warm(input string tag);
        repeat (LAT) step();
        check(tag, 64'(dbg_state_o), 64'(ST_RUN));
    endtask

    task automatic sample(input logic [MW-1:0] m, input logic [MSG-1:0] msg);
        metric_i = m;
        msg_i    = msg;
        step();
        metric_i = '0;
        msg_i    = '0;
    endtask

    task automatic stop_sample();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 40) begin
            step();
            n++;
        end
        check(tag, 64'(busy_o), 64'd0);
    endtask

    task automatic run_basic(input int tn);
        do_start(9'd200);
        warm("t1_run_entry");
        exp_q.push_back({9'd3, mk_msg(tn, 0)});
        exp_q.push_back({9'd7, mk_msg(tn, 1)});
        exp_q.push_back({9'd9, mk_msg(tn, 4)});
        sample(9'd3, mk_msg(tn, 0));
        sample(9'd7, mk_msg(tn, 1));
        sample(9'd7, mk_msg(tn, 2));
        sample(9'd5, mk_msg(tn, 3));
        sample(9'd9, mk_msg(tn, 4));
        stop_sample();
        wait_idle("t1_idle");
        check("t1_samples", 64'(samples_o), 64'd6);
        check("t1_hit", 64'(hit_o), 64'd0);
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);
        check("t1_hold_metric", 64'(bif.best_metric), 64'd9);
        check("t1_hold_msg", 64'(bif.best_msg), 64'(mk_msg(tn, 4)));
    endtask

    initial begin
        reset_ni     = 1'b0;
        start_i      = 1'b0;
        stop_i       = 1'b0;
        thresh_i     = '0;
        metric_i     = '0;
        msg_i        = '0;
        bif.best_rdy = 1'b1;
        repeat (3) step();
        check("rst_val", 64'(bif.best_val), 64'd0);
        check("rst_metric", 64'(bif.best_metric), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_samples", 64'(samples_o), 64'd0);
        check("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
        reset_ni = 1'b1;
        step();

        // 1: rising metrics with a tie
        run_basic(1);

        // 2: warm-up garbage ignored, only RUN cycles counted
        do_start(9'd200);
        metric_i = 9'd150;
        msg_i    = mk_msg(2, 99);
        step();
        metric_i = '0;
        msg_i    = '0;
        repeat (LAT - 1) step();
        check("t2_run_entry", 64'(dbg_state_o), 64'(ST_RUN));
        check("t2_samples_warm", 64'(samples_o), 64'd0);
        exp_q.push_back({9'd5, mk_msg(2, 0)});
        exp_q.push_back({9'd6, mk_msg(2, 1)});
        sample(9'd5, mk_msg(2, 0));
        sample(9'd6, mk_msg(2, 1));
        stop_sample();
        wait_idle("t2_idle");
        check("t2_samples", 64'(samples_o), 64'd3);

        // 3: host stalls; intermediate best never reported
        do_start(9'd200);
        warm("t3_run_entry");
        bif.best_rdy = 1'b0;
        exp_q.push_back({9'd10, mk_msg(3, 0)});
        exp_q.push_back({9'd30, mk_msg(3, 2)});
        sample(9'd10, mk_msg(3, 0));
        sample(9'd20, mk_msg(3, 1));
        sample(9'd30, mk_msg(3, 2));
        stop_sample();
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_val", 64'(bif.best_val), 64'd1);
            check("t3_hold_metric", 64'(bif.best_metric), 64'd10);
            check("t3_hold_msg", 64'(bif.best_msg), 64'(mk_msg(3, 0)));
            step();
        end
        bif.best_rdy = 1'b1;
        wait_idle("t3_idle");
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // 4: threshold hit ends the search
        do_start(9'd40);
        warm("t4_run_entry");
        exp_q.push_back({9'd12, mk_msg(4, 0)});
        exp_q.push_back({9'd45, mk_msg(4, 1)});
        sample(9'd12, mk_msg(4, 0));
        sample(9'd45, mk_msg(4, 1));
        check("t4_drain", 64'(dbg_state_o), 64'(ST_DRAIN));
        wait_idle("t4_idle");
        check("t4_hit", 64'(hit_o), 64'd1);
        check("t4_samples", 64'(samples_o), 64'd2);
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // 5a: stop during WARM, no report
        do_start(9'd200);
        check("t5a_hit_cleared", 64'(hit_o), 64'd0);
        stop_sample();
        check("t5a_drain", 64'(dbg_state_o), 64'(ST_DRAIN));
        step();
        check("t5a_idle", 64'(busy_o), 64'd0);
        check("t5a_val", 64'(bif.best_val), 64'd0);

        // 5b: stop in RUN with a sample on the same cycle
        do_start(9'd200);
        warm("t5b_run_entry");
        exp_q.push_back({9'd60, mk_msg(5, 0)});
        stop_i = 1'b1;
        sample(9'd60, mk_msg(5, 0));
        stop_i = 1'b0;
        wait_idle("t5b_idle");
        check("t5b_samples", 64'(samples_o), 64'd1);
        check("t5b_q_empty", 64'(exp_q.size()), 64'd0);

        // 6: reset mid-RUN drops a pending report
        do_start(9'd200);
        warm("t6_run_entry");
        bif.best_rdy = 1'b0;
        sample(9'd10, mk_msg(6, 0));
        sample(9'd20, mk_msg(6, 1));
        check("t6_pending_val", 64'(bif.best_val), 64'd1);
        reset_ni = 1'b0;
        step();
        check("t6_rst_val", 64'(bif.best_val), 64'd0);
        check("t6_rst_metric", 64'(bif.best_metric), 64'd0);
        check("t6_rst_msg", 64'(bif.best_msg), 64'd0);
        check("t6_rst_busy", 64'(busy_o), 64'd0);
        check("t6_rst_hit", 64'(hit_o), 64'd0);
        check("t6_rst_samples", 64'(samples_o), 64'd0);
        check("t6_rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
        reset_ni     = 1'b1;
        bif.best_rdy = 1'b1;
        step();
        run_basic(7);

        check("final_q_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
